fabric2_arbiter: RTL and testbench

- Two-master OCP arbiter placed in front of the fabric master-port switch.
- Shares the single downstream OCP master path between the instruction-fetch (I) and data (D) masters of the CPU.
- Grants one outstanding transaction at a time, with round-robin priority.
- Guards the response phase with a timeout watchdog that returns SResp ERR.

---
 rtl/fabric2_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fabric2_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric2_arbiter.sv
// Two-master OCP arbiter in front of the fabric master-port switch.
// Shares one downstream OCP path between the CPU I and D masters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_I_M*, o_I_S*           instruction-fetch master command / response
//   i_D_M*, o_D_S*           data master command / response
//   o_M*                     downstream command to the master switch
//   i_S*                     downstream accept / read data / response
//   o_grant                  one-hot grant (bit0 = I, bit1 = D), 00 idle
//
// One transaction is outstanding at a time. Ties go round-robin, and a
// response watchdog answers ERR if the slave never responds.
module fabric2_arbiter #(
    parameter int TIMEOUT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BEN_WIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_I_MAddr,
    input  logic [2:0]            i_I_MCmd,
    input  logic [DATA_WIDTH-1:0] i_I_MData,
    input  logic [BEN_WIDTH-1:0]  i_I_MByteEn,
    output logic                  o_I_SCmdAccept,
    output logic [DATA_WIDTH-1:0] o_I_SData,
    output logic [1:0]            o_I_SResp,
    input  logic [ADDR_WIDTH-1:0] i_D_MAddr,
    input  logic [2:0]            i_D_MCmd,
    input  logic [DATA_WIDTH-1:0] i_D_MData,
    input  logic [BEN_WIDTH-1:0]  i_D_MByteEn,
    output logic                  o_D_SCmdAccept,
    output logic [DATA_WIDTH-1:0] o_D_SData,
    output logic [1:0]            o_D_SResp,
    output logic [ADDR_WIDTH-1:0] o_MAddr,
    output logic [2:0]            o_MCmd,
    output logic [DATA_WIDTH-1:0] o_MData,
    output logic [BEN_WIDTH-1:0]  o_MByteEn,
    input  logic                  i_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_SData,
    input  logic [1:0]            i_SResp,
    output logic [1:0]            o_grant
);

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RESP
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               grant_q, grant_d;
    // last-served pointer: 1 = D was served last, so I wins the next tie
    logic                     last_q, last_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0]    g_addr;
    logic [2:0]               g_cmd;
    logic [DATA_WIDTH-1:0]    g_data;
    logic [BEN_WIDTH-1:0]     g_ben;
    logic                     s_acc;
    logic [DATA_WIDTH-1:0]    s_data;
    logic [1:0]               s_resp;
    logic                     req_i, req_d;

    assign req_i  = (i_I_MCmd != CMD_IDLE);
    assign req_d  = (i_D_MCmd != CMD_IDLE);

    assign g_addr = grant_q[1] ? i_D_MAddr   : i_I_MAddr;
    assign g_cmd  = grant_q[1] ? i_D_MCmd    : i_I_MCmd;
    assign g_data = grant_q[1] ? i_D_MData   : i_I_MData;
    assign g_ben  = grant_q[1] ? i_D_MByteEn : i_I_MByteEn;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        o_MAddr   = '0;
        o_MCmd    = CMD_IDLE;
        o_MData   = '0;
        o_MByteEn = '0;
        s_acc     = 1'b0;
        s_data    = '0;
        s_resp    = RESP_NULL;

        unique case (state_q)
            IDLE: begin
                grant_d = 2'b00;
                if (req_i && req_d) begin
                    grant_d = last_q ? 2'b01 : 2'b10;
                end else if (req_i) begin
                    grant_d = 2'b01;
                end else if (req_d) begin
                    grant_d = 2'b10;
                end
                if (req_i || req_d) begin
                    state_d = CMD;
                end
            end

            CMD: begin
                o_MAddr   = g_addr;
                o_MCmd    = g_cmd;
                o_MData   = g_data;
                o_MByteEn = g_ben;
                s_acc     = i_SCmdAccept;
                s_data    = i_SData;
                s_resp    = i_SResp;
                // A withdrawn command is abandoned without a response
                // and does not count as served.
                if (g_cmd == CMD_IDLE) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else if (i_SCmdAccept) begin
                    if (i_SResp != RESP_NULL) begin
                        last_d  = grant_q[1];
                        state_d = IDLE;
                        grant_d = 2'b00;
                    end else begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end
                end
            end

            RESP: begin
                o_MAddr   = g_addr;
                o_MData   = g_data;
                o_MByteEn = g_ben;
                s_data    = i_SData;
                s_resp    = i_SResp;
                cnt_d     = cnt_q + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
                if (i_SResp != RESP_NULL) begin
                    last_d  = grant_q[1];
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else if (&cnt_q) begin
                    s_resp  = RESP_ERR;
                    s_data  = '0;
                    last_d  = grant_q[1];
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign o_grant        = grant_q;
    assign o_I_SCmdAccept = grant_q[0] & s_acc;
    assign o_I_SData      = grant_q[0] ? s_data : '0;
    assign o_I_SResp      = grant_q[0] ? s_resp : RESP_NULL;
    assign o_D_SCmdAccept = grant_q[1] & s_acc;
    assign o_D_SData      = grant_q[1] ? s_data : '0;
    assign o_D_SResp      = grant_q[1] ? s_resp : RESP_NULL;

endmodule

// File: tb/tb_fabric2_arbiter.sv
// Testbench for fabric2_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration/slave model.
module tb_fabric2_arbiter;

    localparam int TW  = 4;
    localparam int TMO = (1 << TW) - 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] i_I_MAddr, i_I_MData, i_D_MAddr, i_D_MData;
    logic [2:0]  i_I_MCmd, i_D_MCmd;
    logic [3:0]  i_I_MByteEn, i_D_MByteEn;
    logic        o_I_SCmdAccept, o_D_SCmdAccept;
    logic [31:0] o_I_SData, o_D_SData;
    logic [1:0]  o_I_SResp, o_D_SResp;
    logic [31:0] o_MAddr, o_MData;
    logic [2:0]  o_MCmd;
    logic [3:0]  o_MByteEn;
    logic        i_SCmdAccept;
    logic [31:0] i_SData;
    logic [1:0]  i_SResp;
    logic [1:0]  o_grant;

    fabric2_arbiter #(.TIMEOUT_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .i_I_MAddr(i_I_MAddr), .i_I_MCmd(i_I_MCmd),
        .i_I_MData(i_I_MData), .i_I_MByteEn(i_I_MByteEn),
        .o_I_SCmdAccept(o_I_SCmdAccept), .o_I_SData(o_I_SData),
        .o_I_SResp(o_I_SResp),
        .i_D_MAddr(i_D_MAddr), .i_D_MCmd(i_D_MCmd),
        .i_D_MData(i_D_MData), .i_D_MByteEn(i_D_MByteEn),
        .o_D_SCmdAccept(o_D_SCmdAccept), .o_D_SData(o_D_SData),
        .o_D_SResp(o_D_SResp),
        .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MData(o_MData),
        .o_MByteEn(o_MByteEn),
        .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData), .i_SResp(i_SResp),
        .o_grant(o_grant)
    );

    typedef struct packed {
        logic [1:0]  grant;
        logic [2:0]  mcmd;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [3:0]  mben;
        logic [1:0]  acc;
        logic [31:0] odata;
    } exp_t;

    typedef enum {M_ARB, M_CMD, M_RESP} mst_t;

    exp_t        cyc_q[$];
    logic [33:0] rq_i[$];
    logic [33:0] rq_d[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 0;

    // transaction-level model of arbiter + slave
    mst_t        ms;
    int          owner;
    bit          last_d;
    int          acc_cnt, rdelay, rcnt, stray_cnt;
    bit          rst_req, rnd_slave;
    int          pol_acc, pol_mode, pol_rdly;
    logic [31:0] pol_rdata;

    // master state
    logic [2:0]  m_cmd[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_data[2];
    logic [3:0]  m_ben[2];
    bit          busy[2];
    int          hold[2];
    bit          accepted[2];
    bit          done[2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_r(input int k, input logic [1:0] r,
                          input logic [31:0] d);
        if (k == 0) rq_i.push_back({r, d});
        else        rq_d.push_back({r, d});
    endtask

    task automatic finish_txn(input int k);
        last_d  = (k == 1);
        done[k] = 1'b1;
        ms      = M_ARB;
    endtask

    // one clock cycle: drive inputs, advance the model, queue expectations
    task automatic step();
        exp_t        e;
        int          o;
        bit          ri, rd, tmo_now;
        logic        s_acc;
        logic [1:0]  s_resp;
        logic [31:0] s_data;
        @(posedge clk);
        #1;
        rst         = rst_req;
        i_I_MCmd    = m_cmd[0];
        i_I_MAddr   = m_addr[0];
        i_I_MData   = m_data[0];
        i_I_MByteEn = m_ben[0];
        i_D_MCmd    = m_cmd[1];
        i_D_MAddr   = m_addr[1];
        i_D_MData   = m_data[1];
        i_D_MByteEn = m_ben[1];
        for (int k = 0; k < 2; k++) begin
            accepted[k] = 1'b0;
            done[k]     = 1'b0;
        end
        s_acc   = 1'b0;
        s_resp  = 2'b00;
        s_data  = $urandom;
        tmo_now = 1'b0;
        e       = '0;
        o       = owner;
        if (ms != M_ARB) begin
            e.grant = (o == 0) ? 2'b01 : 2'b10;
            e.maddr = m_addr[o];
            e.mdata = m_data[o];
            e.mben  = m_ben[o];
            e.mcmd  = (ms == M_CMD) ? m_cmd[o] : 3'b000;
        end
        if (rst_req) begin
            ms        = M_ARB;
            last_d    = 1'b1;
            stray_cnt = 0;
        end else begin
            case (ms)
                M_ARB: begin
                    if (stray_cnt > 0) begin
                        stray_cnt--;
                        if (stray_cnt == 0) s_resp = 2'b01;
                    end
                    ri = (m_cmd[0] != 3'b000);
                    rd = (m_cmd[1] != 3'b000);
                    if (ri && rd) owner = last_d ? 0 : 1;
                    else if (ri)  owner = 0;
                    else if (rd)  owner = 1;
                    if (ri || rd) begin
                        ms = M_CMD;
                        if (rnd_slave) begin
                            pol_acc   = $urandom_range(0, 3);
                            pol_rdly  = $urandom_range(0, 5);
                            pol_rdata = $urandom;
                            case ($urandom_range(0, 9))
                                0, 1, 2: pol_mode = 0;
                                9:       pol_mode = 2;
                                default: pol_mode = 1;
                            endcase
                        end
                        acc_cnt = pol_acc;
                    end
                end
                M_CMD: begin
                    if (m_cmd[o] == 3'b000) begin
                        ms     = M_ARB;
                        s_data = '0;
                    end else if (acc_cnt > 0) begin
                        acc_cnt--;
                    end else begin
                        s_acc       = 1'b1;
                        e.acc[o]    = 1'b1;
                        accepted[o] = 1'b1;
                        if (pol_mode == 0) begin
                            s_resp = 2'b01;
                            s_data = pol_rdata;
                            push_r(o, 2'b01, pol_rdata);
                            finish_txn(o);
                        end else begin
                            ms     = M_RESP;
                            rdelay = pol_rdly;
                            rcnt   = 0;
                        end
                    end
                end
                M_RESP: begin
                    if (pol_mode == 2) begin
                        if (rcnt == TMO) begin
                            tmo_now = 1'b1;
                            push_r(o, 2'b11, 32'h0);
                            finish_txn(o);
                        end else begin
                            rcnt++;
                        end
                    end else if (rdelay == 0) begin
                        s_resp = 2'b01;
                        s_data = pol_rdata;
                        push_r(o, 2'b01, pol_rdata);
                        finish_txn(o);
                    end else begin
                        rdelay--;
                    end
                end
                default: ms = M_ARB;
            endcase
        end
        e.odata      = tmo_now ? 32'h0 : s_data;
        i_SCmdAccept = s_acc;
        i_SResp      = s_resp;
        i_SData      = s_data;
        cyc_q.push_back(e);
    endtask

    // mode 0: directed (no new requests), 1: random, 2: continuous RD
    task automatic upd(input int mode);
        for (int k = 0; k < 2; k++) begin
            if (accepted[k]) m_cmd[k] = 3'b000;
            if (done[k]) begin
                busy[k] = 1'b0;
                hold[k] = (mode == 1) ? $urandom_range(0, 3) : 0;
            end
            if (mode != 0 && !busy[k]) begin
                if (hold[k] > 0) begin
                    hold[k]--;
                end else begin
                    m_cmd[k]  = (mode == 2) ? 3'b010
                                : 3'($urandom_range(1, 2));
                    m_addr[k] = $urandom;
                    m_data[k] = $urandom;
                    m_ben[k]  = 4'($urandom_range(1, 15));
                    busy[k]   = 1'b1;
                end
            end
        end
    endtask

    task automatic run(input int n, input int mode);
        repeat (n) begin
            step();
            upd(mode);
        end
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while ((busy[0] || busy[1] || ms != M_ARB) && c < maxc) begin
            step();
            upd(0);
            c++;
        end
        if (busy[0] || busy[1] || ms != M_ARB) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_bound: still busy after %0d cycles", maxc);
        end
    endtask

    task automatic req(input int k, input logic [2:0] cmd,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
        m_cmd[k]  = cmd;
        m_addr[k] = a;
        m_data[k] = d;
        m_ben[k]  = b;
        busy[k]   = 1'b1;
    endtask

    task automatic policy(input int a, input int mode, input int rdly,
                          input logic [31:0] rdata);
        pol_acc   = a;
        pol_mode  = mode;
        pol_rdly  = rdly;
        pol_rdata = rdata;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        exp_t        e;
        logic [33:0] r;
        if (mon_en && cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("grant", 32'(o_grant), 32'(e.grant));
            chk("MCmd", 32'(o_MCmd), 32'(e.mcmd));
            chk("MAddr", o_MAddr, e.maddr);
            chk("MData", o_MData, e.mdata);
            chk("MByteEn", 32'(o_MByteEn), 32'(e.mben));
            chk("I_accept", 32'(o_I_SCmdAccept), 32'(e.acc[0]));
            chk("D_accept", 32'(o_D_SCmdAccept), 32'(e.acc[1]));
            chk("I_SData", o_I_SData, e.grant[0] ? e.odata : 32'h0);
            chk("D_SData", o_D_SData, e.grant[1] ? e.odata : 32'h0);
        end
        if (mon_en && o_I_SResp !== 2'b00) begin
            if (rq_i.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL I_resp_unexpected: got %b expected 00", o_I_SResp);
            end else begin
                r = rq_i.pop_front();
                chk("I_SResp", 32'(o_I_SResp), 32'(r[33:32]));
                chk("I_rdata", o_I_SData, r[31:0]);
            end
        end
        if (mon_en && o_D_SResp !== 2'b00) begin
            if (rq_d.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL D_resp_unexpected: got %b expected 00", o_D_SResp);
            end else begin
                r = rq_d.pop_front();
                chk("D_SResp", 32'(o_D_SResp), 32'(r[33:32]));
                chk("D_rdata", o_D_SData, r[31:0]);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        i_I_MAddr    = '0; i_I_MCmd = '0; i_I_MData = '0; i_I_MByteEn = '0;
        i_D_MAddr    = '0; i_D_MCmd = '0; i_D_MData = '0; i_D_MByteEn = '0;
        i_SCmdAccept = 1'b0; i_SData = '0; i_SResp = 2'b00;
        for (int k = 0; k < 2; k++) begin
            m_cmd[k] = '0; m_addr[k] = '0; m_data[k] = '0; m_ben[k] = '0;
            busy[k] = 1'b0; hold[k] = 0; accepted[k] = 1'b0; done[k] = 1'b0;
        end
        ms = M_ARB; owner = 0; last_d = 1'b1;
        acc_cnt = 0; rdelay = 0; rcnt = 0; stray_cnt = 0;
        rst_req = 1'b0; rnd_slave = 1'b0;
        policy(0, 1, 0, 32'h0);
        repeat (3) @(posedge clk);
        mon_en = 1'b1;

        // reset state
        run(2, 0);

        // single I read
        req(0, 3'b010, 32'h1000_0000, 32'h0, 4'hF);
        policy(2, 1, 0, 32'hDEAD_BEEF);
        drain(20);
        run(1, 0);

        // contention from reset
        rst_req = 1'b1; step(); rst_req = 1'b0;
        policy(0, 1, 1, 32'hCAFE_0001);
        run(24, 2);
        drain(40);

        // same-cycle accept and response
        req(1, 3'b001, 32'h2000_0040, 32'h1234_5678, 4'hF);
        policy(0, 0, 0, 32'h0);
        drain(20);
        run(1, 0);

        // timeout followed by a stray response
        req(0, 3'b010, 32'h1000_0004, 32'h0, 4'hF);
        policy(0, 2, 0, 32'h0);
        drain(40);
        stray_cnt = 2;
        run(4, 0);

        // reset while D is in RESP
        req(1, 3'b010, 32'h3000_0000, 32'h0, 4'h3);
        policy(0, 1, 8, 32'h5555_AAAA);
        run(4, 0);
        rst_req = 1'b1; step(); rst_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cmd[k] = 3'b000;
            busy[k]  = 1'b0;
        end
        run(1, 0);
        req(0, 3'b010, 32'h1000_0100, 32'h0, 4'hF);
        req(1, 3'b010, 32'h3000_0100, 32'h0, 4'hF);
        policy(0, 1, 0, 32'h0BAD_F00D);
        drain(40);

        // command withdrawal with a pending D request
        req(0, 3'b010, 32'h1000_0200, 32'h0, 4'hF);
        policy(10, 1, 0, 32'h0);
        run(2, 0);
        req(1, 3'b001, 32'h3000_0200, 32'hA5A5_5A5A, 4'hC);
        run(1, 0);
        m_cmd[0] = 3'b000;
        busy[0]  = 1'b0;
        policy(0, 1, 0, 32'h7777_0000);
        drain(40);

        // random traffic
        rnd_slave = 1'b1;
        run(3000, 1);
        drain(200);
        run(2, 0);

        @(negedge clk);
        #1;
        chk("I_resp_pending", 32'(rq_i.size()), 32'h0);
        chk("D_resp_pending", 32'(rq_d.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
